// File: rtl/multi_driver_resolver_if.sv
// Bundle of driver inputs and resolved channel outputs for multi_driver_resolver.
// The master side drives the candidate sources; the slave side is the resolver.
interface multi_driver_resolver_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NCH*NSRC*WIDTH-1:0] src_data;
  logic [NCH*NSRC-1:0]       src_conn;
  logic [NCH*NSRC-1:0]       src_req;
  logic [NCH*WIDTH-1:0]      out_data;
  logic [NCH-1:0]            out_valid;
  logic [NCH*SRC_W-1:0]      out_src;
  logic [NCH-1:0]            conflict;
  logic [NCH-1:0]            floating;
  logic [CNT_W-1:0]          conflict_cnt;

  modport master (
    output src_data, src_conn, src_req,
    input  out_data, out_valid, out_src, conflict, floating, conflict_cnt
  );

  modport slave (
    input  src_data, src_conn, src_req,
    output out_data, out_valid, out_src, conflict, floating, conflict_cnt
  );
endinterface

// File: rtl/multi_driver_resolver.sv
// Per-channel resolver of several optionally-connected drivers with contention/float flags.
// Optional macro MDR_FIXED_PRIORITY_EN: highest-index eligible driver wins instead of round-robin.
module multi_driver_resolver #(
  parameter int unsigned           WIDTH   = 8,
  parameter int unsigned           NSRC    = 2,
  parameter int unsigned           NCH     = 2,
  parameter logic [WIDTH-1:0]      TIE_VAL = '0,
  parameter int unsigned           CNT_W   = 16
) (
  input logic                      clk,
  input logic                      rst,
  multi_driver_resolver_if.slave   bus
);
  localparam int unsigned SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NCH*WIDTH-1:0] out_data_q,  out_data_d;
  logic [NCH-1:0]       out_valid_q, out_valid_d;
  logic [NCH*SRC_W-1:0] out_src_q,   out_src_d;
  logic [NCH-1:0]       conflict_q,  conflict_d;
  logic [NCH-1:0]       floating_q,  floating_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
`ifndef MDR_FIXED_PRIORITY_EN
  logic [NCH*SRC_W-1:0] ptr_q,       ptr_d;
`endif

  // Per-channel eligibility, grant selection and next-state outputs
  always_comb begin
    logic [NSRC-1:0] conn;
    logic [NSRC-1:0] elig;
    int unsigned     g;
`ifndef MDR_FIXED_PRIORITY_EN
    int unsigned     idx;
    logic            found;
`endif
    out_data_d  = out_data_q;
    out_valid_d = '0;
    out_src_d   = out_src_q;
    conflict_d  = '0;
    floating_d  = '0;
    cnt_d       = cnt_q;
`ifndef MDR_FIXED_PRIORITY_EN
    ptr_d       = ptr_q;
`endif
    for (int unsigned c = 0; c < NCH; c++) begin
      conn = bus.src_conn[c*NSRC +: NSRC];
      elig = conn & bus.src_req[c*NSRC +: NSRC];
      g    = 0;
`ifdef MDR_FIXED_PRIORITY_EN
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (elig[s]) g = s;
      end
`else
      // First eligible driver at or after the pointer, wrapping to 0
      found = 1'b0;
      for (int unsigned k = 0; k < NSRC; k++) begin
        idx = 32'(ptr_q[c*SRC_W +: SRC_W]) + k;
        if (idx >= NSRC) idx = idx - NSRC;
        if (!found && elig[idx]) begin
          g     = idx;
          found = 1'b1;
        end
      end
`endif
      if (conn == '0) begin
        floating_d[c]                  = 1'b1;
        out_data_d[c*WIDTH +: WIDTH]   = TIE_VAL;
      end else if (elig != '0) begin
        out_data_d[c*WIDTH +: WIDTH]   = bus.src_data[(c*NSRC + g)*WIDTH +: WIDTH];
        out_src_d[c*SRC_W +: SRC_W]    = SRC_W'(g);
        out_valid_d[c]                 = 1'b1;
        conflict_d[c]                  = (elig & (elig - NSRC'(1))) != '0;
`ifndef MDR_FIXED_PRIORITY_EN
        ptr_d[c*SRC_W +: SRC_W]        = (g == NSRC - 1) ? SRC_W'(0) : SRC_W'(g + 1);
`endif
      end
    end
    // Saturating accumulation, one step per conflicting channel
    for (int unsigned c = 0; c < NCH; c++) begin
      if (conflict_d[c] && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= {NCH{TIE_VAL}};
      out_valid_q <= '0;
      out_src_q   <= '0;
      conflict_q  <= '0;
      floating_q  <= '1;
      cnt_q       <= '0;
`ifndef MDR_FIXED_PRIORITY_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      conflict_q  <= conflict_d;
      floating_q  <= floating_d;
      cnt_q       <= cnt_d;
`ifndef MDR_FIXED_PRIORITY_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_src      = out_src_q;
  assign bus.conflict     = conflict_q;
  assign bus.floating     = floating_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_multi_driver_resolver.sv
// Directed-vector bench for multi_driver_resolver (round-robin or MDR_FIXED_PRIORITY_EN build).
module tb_multi_driver_resolver;
`ifdef MDR_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [7:0] TIE = 8'h3C;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  multi_driver_resolver_if #(.WIDTH(8), .NSRC(2), .NCH(2), .CNT_W(16)) m_if ();
  multi_driver_resolver_if #(.WIDTH(8), .NSRC(2), .NCH(1), .CNT_W(2))  s_if ();

  multi_driver_resolver #(.WIDTH(8), .NSRC(2), .NCH(2), .TIE_VAL(TIE), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  multi_driver_resolver #(.WIDTH(8), .NSRC(2), .NCH(1), .TIE_VAL(8'h00), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned c, input logic [1:0] conn, input logic [1:0] req,
                       input logic [7:0] d0, input logic [7:0] d1);
    m_if.src_conn[c*2 +: 2]      = conn;
    m_if.src_req[c*2 +: 2]       = req;
    m_if.src_data[c*16 +: 8]     = d0;
    m_if.src_data[c*16 + 8 +: 8] = d1;
  endtask

  initial begin
    rst           = 1'b1;
    m_if.src_conn = '0;
    m_if.src_req  = '0;
    m_if.src_data = '0;
    s_if.src_conn = '0;
    s_if.src_req  = '0;
    s_if.src_data = '0;
    step();
    step();
    check("rst_data",   32'(m_if.out_data),     32'h3C3C);
    check("rst_float",  32'(m_if.floating),     32'h3);
    check("rst_valid",  32'(m_if.out_valid),    32'h0);
    check("rst_cnt",    32'(m_if.conflict_cnt), 32'h0);
    check("rst_src",    32'(m_if.out_src),      32'h0);
    rst = 1'b0;
    step();
    check("idle_float", 32'(m_if.floating),     32'h3);
    check("idle_data",  32'(m_if.out_data),     32'h3C3C);

    // single connected, requesting driver on ch0
    drive(0, 2'b01, 2'b01, 8'hA5, 8'h00);
    step();
    check("one_data",  32'(m_if.out_data[7:0]), 32'hA5);
    check("one_src",   32'(m_if.out_src[0]),    32'h0);
    check("one_valid", 32'(m_if.out_valid),     32'h1);
    check("one_conf",  32'(m_if.conflict),      32'h0);
    check("one_float", 32'(m_if.floating),      32'h2);

    // one-hot on src1 realigns the pointer to 0
    drive(0, 2'b11, 2'b10, 8'h00, 8'hBB);
    step();
    check("hi_data", 32'(m_if.out_data[7:0]), 32'hBB);
    check("hi_src",  32'(m_if.out_src[0]),    32'h1);
    check("hi_conf", 32'(m_if.conflict),      32'h0);

    // sustained contention on ch0
    drive(0, 2'b11, 2'b11, 8'h11, 8'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_data", 32'(m_if.out_data[7:0]), FIXED ? 32'h22 : ((i % 2 == 0) ? 32'h11 : 32'h22));
      check("rr_src",  32'(m_if.out_src[0]),    FIXED ? 32'h1  : 32'(i % 2));
      check("rr_conf", 32'(m_if.conflict),      32'h1);
      check("rr_cnt",  32'(m_if.conflict_cnt),  32'(i + 1));
    end

    // requesting but unconnected src0 is ignored
    drive(0, 2'b10, 2'b11, 8'h77, 8'h99);
    step();
    check("empty_data",  32'(m_if.out_data[7:0]), 32'h99);
    check("empty_src",   32'(m_if.out_src[0]),    32'h1);
    check("empty_conf",  32'(m_if.conflict),      32'h0);
    check("empty_cnt",   32'(m_if.conflict_cnt),  32'h4);
    drive(0, 2'b10, 2'b00, 8'h77, 8'h55);
    step();
    check("hold_data",  32'(m_if.out_data[7:0]), 32'h99);
    check("hold_valid", 32'(m_if.out_valid),     32'h0);
    check("hold_float", 32'(m_if.floating),      32'h2);

    // contention on both channels in the same cycle
    drive(0, 2'b11, 2'b11, 8'h11, 8'h22);
    drive(1, 2'b11, 2'b11, 8'h33, 8'h44);
    step();
    check("dual_data", 32'(m_if.out_data), FIXED ? 32'h4422 : 32'h3311);
    check("dual_conf", 32'(m_if.conflict),     32'h3);
    check("dual_cnt",  32'(m_if.conflict_cnt), 32'h6);

    // ch1 loses all connections while ch0 keeps contending
    drive(1, 2'b00, 2'b11, 8'h33, 8'h44);
    step();
    check("flt_data",  32'(m_if.out_data), FIXED ? 32'h3C22 : 32'h3C22);
    check("flt_float", 32'(m_if.floating),     32'h2);
    check("flt_valid", 32'(m_if.out_valid),    32'h1);
    check("flt_src",   32'(m_if.out_src),      FIXED ? 32'h3 : 32'h1);
    check("flt_cnt",   32'(m_if.conflict_cnt), 32'h7);
    step();
    check("pre_rst_data", 32'(m_if.out_data[7:0]), FIXED ? 32'h22 : 32'h11);
    check("pre_rst_cnt",  32'(m_if.conflict_cnt),  32'h8);

    // asynchronous reset in the middle of a cycle
    #3 rst = 1'b1;
    #1;
    check("arst_data",  32'(m_if.out_data),     32'h3C3C);
    check("arst_cnt",   32'(m_if.conflict_cnt), 32'h0);
    check("arst_float", 32'(m_if.floating),     32'h3);
    check("arst_valid", 32'(m_if.out_valid),    32'h0);
    step();
    rst = 1'b0;
    step();
    check("rel_data", 32'(m_if.out_data[7:0]), FIXED ? 32'h22 : 32'h11);
    check("rel_src",  32'(m_if.out_src[0]),    FIXED ? 32'h1  : 32'h0);
    check("rel_cnt",  32'(m_if.conflict_cnt),  32'h1);

    // narrow counter saturation
    s_if.src_conn = 2'b11;
    s_if.src_req  = 2'b11;
    s_if.src_data = 16'h2211;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat_cnt", 32'(s_if.conflict_cnt), (i < 3) ? 32'(i + 1) : 32'h3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
